fetch_unit: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to instruction memory over a request/grant bus with in-order, variable-latency responses.
- Buffers returned instructions in a 2-entry queue and presents one instruction per cycle to IF/ID.
- Honours the pipeline stall, and on a taken branch flushes and redirects to the branch target.

---
 rtl/fetch_unit_if.sv | 19 +
 rtl/fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant bus between the fetch unit and imem.
// Responses return in request order, earliest one cycle after the grant.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues imem word requests under a 2-credit
// budget, buffers returned instructions and handles stall/flush redirect.
module fetch_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b11: begin
          // Entry 0 is always the head; a simultaneous push/pop slides entry 1 down.
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = din_i;
          end else begin
            e0_d = din_i;
          end
        end
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = din_i;
          else               e1_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o = e0_q;
  assign cnt_o  = cnt_q;
endmodule

module fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [31:0]         branch_target_i,
  fetch_unit_if.master        imem,
  output logic                inst_valid_o,
  output logic [31:0]         inst_o,
  output logic [31:0]         pc_o
);
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  disc_q, disc_d;
  logic        run_q, run_d;

  logic        grant, rsp_acc, rsp_keep, iq_pop;
  logic [31:0] af_dout;
  logic [1:0]  af_cnt, iq_cnt;
  logic [63:0] iq_dout;

  // run_q keeps the request line low while reset is asserted.
  assign run_d    = 1'b1;
  assign rsp_acc  = imem.imem_rvalid_i && (outst_q != 2'd0);
  assign rsp_keep = rsp_acc && (disc_q == 2'd0);
  assign grant    = imem.imem_req_o && imem.imem_gnt_i;
  assign iq_pop   = inst_valid_o && !stall_i;

  // Credit counts both in-flight requests and buffered instructions, so every
  // response is guaranteed a queue slot.
  assign imem.imem_req_o  = run_q && !flush_i &&
                            (({1'b0, outst_q} + {1'b0, iq_cnt}) < 3'(MAX_OUTST));
  assign imem.imem_addr_o = fetch_pc_q;

  fetch_fifo2 #(.W(32)) u_addr_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .push_i (grant),
    .din_i  (fetch_pc_q),
    .pop_i  (rsp_keep),
    .dout_o (af_dout),
    .cnt_o  (af_cnt)
  );

  fetch_fifo2 #(.W(64)) u_inst_q (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .push_i (rsp_keep),
    .din_i  ({af_dout, imem.imem_rdata_i}),
    .pop_i  (iq_pop),
    .dout_o (iq_dout),
    .cnt_o  (iq_cnt)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + {1'b0, grant} - {1'b0, rsp_acc};
    disc_d     = disc_q;
    if (flush_i) begin
      fetch_pc_d = {branch_target_i[31:2], 2'b00};
      // Everything still in flight after this cycle belongs to the old path.
      disc_d     = outst_q - {1'b0, rsp_acc};
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_acc && (disc_q != 2'd0)) disc_d = disc_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q <= PC_RESET;
      outst_q    <= 2'd0;
      disc_q     <= 2'd0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      run_q      <= run_d;
    end
  end

  assign inst_valid_o = (iq_cnt != 2'd0);
  assign inst_o       = inst_valid_o ? iq_dout[31:0]  : 32'h0;
  assign pc_o         = inst_valid_o ? iq_dout[63:32] : 32'h0;

  logic unused_ok;
  assign unused_ok = ^af_cnt;
endmodule
